// File: rtl/usb_data_buffer.sv
// usb_data_buffer: DEPTH-entry byte FIFO shared by AHB and USB sides, with flush and sticky over/underrun flags
module usb_data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_rx_data,
  output logic [7:0] rx_data,
  input  logic       store_rx_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       get_tx_packet_data,
  output logic [7:0] tx_packet_data,
  input  logic       clear,
  input  logic       flush,
  output logic [6:0] buffer_occupancy,
  output logic       overrun,
  output logic       underrun
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [6:0] count_q, count_d;
  logic overrun_q, overrun_d, underrun_q, underrun_d;
  logic fl, push, pop, push_ok, pop_ok;
  logic [7:0] push_byte, head;
  always_comb begin
    fl = clear | flush;
    push = store_tx_data | store_rx_packet_data;
    pop = get_rx_data | get_tx_packet_data;
    push_byte = store_tx_data ? tx_data : rx_packet_data;
    pop_ok = pop & ~fl & (count_q != 7'd0);
    // a pop in the same cycle frees a slot, so a full buffer still accepts the push
    push_ok = push & ~fl & ((count_q != 7'(DEPTH)) | pop_ok);
    wptr_d = fl ? '0 : wptr_q + AW'(push_ok);
    rptr_d = fl ? '0 : rptr_q + AW'(pop_ok);
    count_d = fl ? '0 : count_q + 7'(push_ok) - 7'(pop_ok);
    overrun_d = fl ? 1'b0 : overrun_q | (push & ~push_ok);
    underrun_d = fl ? 1'b0 : underrun_q | (pop & ~pop_ok);
    state_d = fl ? FLUSH : (state_q == FLUSH) ? (push_ok ? ACTIVE : IDLE) : (count_d != 7'd0) ? ACTIVE : IDLE;
    head = mem_q[rptr_q];
    rx_data = (count_q == 7'd0) ? 8'h00 : head;
    tx_packet_data = rx_data;
    buffer_occupancy = count_q;
    overrun = overrun_q;
    underrun = underrun_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      overrun_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      overrun_q <= overrun_d;
      underrun_q <= underrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= push_byte;
  end
endmodule

// File: doc/usb_data_buffer.md
USB_DATA_BUFFER -- requirements
Module: usb_data_buffer

Interface
REQ-001 Parameter: DEPTH, default 64, number of byte entries (power of two).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 store_tx_data  input  1  AHB-side push strobe, one byte per asserted cycle.
REQ-005 tx_data  input  8  AHB-side push byte.
REQ-006 get_rx_data  input  1  AHB-side pop strobe, one byte per asserted cycle.
REQ-007 rx_data  output  8  AHB-side pop byte (show-ahead head entry).
REQ-008 store_rx_packet_data  input  1  USB-RX push strobe.
REQ-009 rx_packet_data  input  8  USB-RX push byte.
REQ-010 get_tx_packet_data  input  1  USB-TX pop strobe.
REQ-011 tx_packet_data  output  8  USB-TX pop byte (show-ahead head entry).
REQ-012 clear  input  1  flush request from the AHB flush register.
REQ-013 flush  input  1  flush request from the USB protocol controller.
REQ-014 buffer_occupancy  output  7  current byte count, 0..DEPTH.
REQ-015 overrun  output  1  sticky: push attempted while full.
REQ-016 underrun  output  1  sticky: pop attempted while empty.

Function
REQ-017 Storage: DEPTH x 8 register array, write pointer wptr and read pointer rptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-018 push = store_tx_data | store_rx_packet_data; push byte = tx_data when store_tx_data is high, else rx_packet_data.
REQ-019 pop = get_rx_data | get_tx_packet_data; both pop strobes high in one cycle remove exactly one byte.
REQ-020 rx_data and tx_packet_data both equal the array entry at rptr, combinationally; both read 8'h00 when buffer_occupancy is 0.
REQ-021 Push accepted when buffer_occupancy < DEPTH: byte written at wptr, wptr increments on that edge.
REQ-022 Pop accepted when buffer_occupancy > 0: rptr increments on that edge; popped byte is the value presented on rx_data/tx_packet_data during that cycle.
REQ-023 Accepted push and accepted pop in the same cycle: both pointers advance, buffer_occupancy unchanged.
REQ-024 Push and pop in the same cycle with buffer_occupancy == 0: push accepted, pop rejected, underrun set, occupancy becomes 1.
REQ-025 Push and pop in the same cycle with buffer_occupancy == DEPTH: pop accepted first, push accepted, occupancy remains DEPTH, overrun not set.
REQ-026 Rejected push (full, no pop): array, wptr and occupancy unchanged; overrun set to 1.
REQ-027 Rejected pop (empty): rptr and occupancy unchanged; underrun set to 1.
REQ-028 buffer_occupancy is a registered counter: +1 on accepted push only, -1 on accepted pop only, else held; it never exceeds DEPTH or goes below 0.
REQ-029 State machine IDLE/ACTIVE/FLUSH; IDLE when occupancy 0 and no push; ACTIVE when occupancy > 0 or push accepted; FLUSH entered from any state on clear | flush.
REQ-030 FLUSH is a one-cycle state: on the edge where clear | flush is sampled high, wptr, rptr and buffer_occupancy go to 0 and pushes/pops that cycle are discarded; next state IDLE, or FLUSH again if clear | flush is still high.
REQ-031 While in FLUSH, push and pop strobes are ignored and do not set overrun or underrun.
REQ-032 overrun and underrun clear only on reset or on a flush (clear | flush); flush has priority over setting them that cycle.
REQ-033 Latency: a byte pushed at edge N is visible on the pop outputs from edge N onward when the buffer was empty (zero bubble).

Reset
REQ-034 On rst high at a clock edge: wptr=0, rptr=0, buffer_occupancy=0, overrun=0, underrun=0, state=IDLE; rx_data and tx_packet_data read 8'h00; array contents need not be cleared.
REQ-035 rst has priority over all other inputs, including mid-transfer pushes, pops and flushes.

Verification
REQ-036 Reset, then push 8'hA5 via store_tx_data for 1 cycle -> buffer_occupancy=1, rx_data=8'hA5 and tx_packet_data=8'hA5 next cycle.
REQ-037 Push bytes 0..63 (DEPTH=64), then a 65th push -> occupancy=64, overrun=1, subsequent 64 pops return 0..63 in order.
REQ-038 Fill 10 bytes, assert get_rx_data and get_tx_packet_data together for 1 cycle -> occupancy=9, only the first byte removed.
REQ-039 Occupancy 64, push 8'h11 and pop together -> occupancy stays 64, overrun=0, 8'h11 read out last after 63 further pops.
REQ-040 Occupancy 5, assert clear with a simultaneous push -> next cycle occupancy=0, rx_data=8'h00, pushed byte discarded.
REQ-041 Empty buffer, pop 1 cycle -> underrun=1, occupancy 0; assert rst mid-fill at occupancy 30 -> occupancy=0, underrun=0 next cycle.
